// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bus bundle between the fetch stage, the instruction ROM and
// the downstream decoder.
//   rom_addr  : fetch -> ROM, address (current pc)
//   rom_data  : ROM -> fetch, combinational instruction word
//   out_valid : fetch -> decoder, out_inst/out_pc hold a valid instruction
//   out_ready : decoder -> fetch, instruction accepted this cycle
//   out_inst  : fetch -> decoder, registered instruction
//   out_pc    : fetch -> decoder, address the instruction came from
// master = fetch stage side, slave = ROM/decoder side.
interface inst_fetch_if #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output rom_addr, out_valid, out_inst, out_pc,
        input  rom_data, out_ready
    );

    modport slave (
        input  rom_addr, out_valid, out_inst, out_pc,
        output rom_data, out_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage in front of a zero-latency ROM.
// Drives the ROM address from pc, registers the returned word and presents
// it to the decoder over valid/ready. Supports jump redirect (flushes the
// held word), back-pressure stalls, a HALT opcode that stops fetching until
// the next jump, and a saturating count of accepted handshakes.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   jump_en    : single-cycle redirect request
//   jump_addr  : redirect target
//   halted     : fetch is parked in HALT
//   fetch_cnt  : accepted handshakes, saturating at all-ones
//   bus        : ROM address/data and decoder valid/ready/inst/pc
module inst_fetch #(
    parameter int                ADDR_W   = 4,
    parameter int                INST_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INST_W-1:0] HALT_OP  = 8'hFF,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_cnt,
    inst_fetch_if.master      bus
);
    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              vld;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] opc;
    logic [CNT_W-1:0]  cnt;

    logic accept;
    logic slot_free;

    assign accept    = vld && bus.out_ready;
    assign slot_free = !vld || bus.out_ready;

    assign bus.rom_addr  = pc;
    assign bus.out_valid = vld;
    assign bus.out_inst  = inst;
    assign bus.out_pc    = opc;
    assign halted        = (state == S_HALT);
    assign fetch_cnt     = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            pc    <= RESET_PC;
            vld   <= 1'b0;
            inst  <= '0;
            opc   <= '0;
            cnt   <= '0;
        end else begin
            // A handshake completing in a jump cycle still retires.
            if (accept && cnt != {CNT_W{1'b1}})
                cnt <= cnt + 1'b1;

            if (jump_en) begin
                pc    <= jump_addr;
                vld   <= 1'b0;
                state <= S_RUN;
            end else if (state == S_RUN) begin
                if (slot_free) begin
                    inst <= bus.rom_data;
                    opc  <= pc;
                    vld  <= 1'b1;
                    // pc stays on the HALT word so rom_addr parks there.
                    if (bus.rom_data == HALT_OP)
                        state <= S_HALT;
                    else
                        pc <= pc + 1'b1;
                end
            end else begin
                // HALT: keep presenting the HALT word until taken.
                if (accept)
                    vld <= 1'b0;
            end
        end
    end
endmodule
